coreaxitoahbl_wstrb_split_ctrl: RTL

// - Sequences AXI write beats into naturally aligned AHB-Lite write transfers, one transfer at a time.
// - For each beat it finds the lowest strobed byte lane and the contiguous byte count.
// - It then splits that byte run into aligned power-of-two transfers of 8/4/2/1 bytes.
// - Sits between the AXI write-data buffer and the AHB master FSM; rejects non-contiguous strobes.

---
 rtl/coreaxitoahbl_wstrb_split_ctrl_pkg.sv | 36 +++
 rtl/coreaxitoahbl_wstrb_split_ctrl_if.sv | 30 +++
 rtl/coreaxitoahbl_wstrb_split_ctrl_popcntr.sv | 33 +++
 rtl/coreaxitoahbl_wstrb_split_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/coreaxitoahbl_wstrb_split_ctrl_pkg.sv
// Shared definitions for the AXI write-strobe to AHB-Lite transfer splitter:
// HSIZE encodings, FSM states and the aligned transfer-size selector.
package coreaxitoahbl_wstrb_split_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Largest naturally aligned power-of-two transfer that fits the remaining run.
  function automatic logic [2:0] size_sel(input logic [2:0] off, input logic [3:0] len,
                                          input logic dw64);
    logic [2:0] sz;
    if (dw64 && (off == 3'd0) && (len >= 4'd8)) begin
      sz = HSIZE_DWORD;
    end else if ((off[1:0] == 2'd0) && (len >= 4'd4)) begin
      sz = HSIZE_WORD;
    end else if ((off[0] == 1'b0) && (len >= 4'd2)) begin
      sz = HSIZE_HALF;
    end else begin
      sz = HSIZE_BYTE;
    end
    return sz;
  endfunction

  // Byte count carried by an HSIZE encoding (up to 8).
  function automatic logic [3:0] size_bytes(input logic [2:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/coreaxitoahbl_wstrb_split_ctrl_if.sv
// Beat-in / transfer-out handshake bundle of the strobe splitter.
interface coreaxitoahbl_wstrb_split_ctrl_if #(
  parameter int AXI_STRBWIDTH = 8,
  parameter int BYTECNT_WIDTH = 12
);
  logic                     BEAT_VALID;
  logic                     BEAT_READY;
  logic [AXI_STRBWIDTH-1:0] BEAT_WSTRB;
  logic                     BEAT_LAST;
  logic                     XFER_VALID;
  logic                     XFER_READY;
  logic [2:0]               XFER_OFFSET;
  logic [2:0]               XFER_SIZE;
  logic                     XFER_BEATEND;
  logic                     STRB_ERR;
  logic                     BURST_DONE;
  logic [BYTECNT_WIDTH-1:0] BYTE_CNT;

  modport slave (
    input  BEAT_VALID, BEAT_WSTRB, BEAT_LAST, XFER_READY,
    output BEAT_READY, XFER_VALID, XFER_OFFSET, XFER_SIZE, XFER_BEATEND,
           STRB_ERR, BURST_DONE, BYTE_CNT
  );

  modport master (
    output BEAT_VALID, BEAT_WSTRB, BEAT_LAST, XFER_READY,
    input  BEAT_READY, XFER_VALID, XFER_OFFSET, XFER_SIZE, XFER_BEATEND,
           STRB_ERR, BURST_DONE, BYTE_CNT
  );
endinterface

// File: rtl/coreaxitoahbl_wstrb_split_ctrl_popcntr.sv
// Strobe population counter: number of set strobe bits when they form one
// contiguous run, 0 for an empty or non-contiguous strobe.
module coreaxitoahbl_wstrb_split_ctrl_popcntr #(
  parameter int AXI_DWIDTH    = 64,
  parameter int AXI_STRBWIDTH = 8
) (
  input  logic [AXI_STRBWIDTH-1:0] i_wstrb,
  output logic [3:0]               o_cnt
);
  localparam int LANES = AXI_DWIDTH / 8;

  logic [AXI_STRBWIDTH-1:0] w_run_start;
  logic [3:0]               w_ones;
  logic [3:0]               w_runs;

  // A lane starts a run when it is set and the lane below it is not.
  assign w_run_start = i_wstrb & ~(i_wstrb << 1);

  // Count set lanes and run starts; only a single run yields a count.
  always_comb begin
    w_ones = 4'd0;
    w_runs = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      w_ones = w_ones + {3'd0, i_wstrb[i]};
      w_runs = w_runs + {3'd0, w_run_start[i]};
    end
    if (w_runs == 4'd1) begin
      o_cnt = w_ones;
    end else begin
      o_cnt = 4'd0;
    end
  end
endmodule

// File: rtl/coreaxitoahbl_wstrb_split_ctrl.sv
// Splits each captured AXI write beat into naturally aligned AHB-Lite
// transfers (8/4/2/1 bytes), one command at a time, and tracks burst bytes.
module coreaxitoahbl_wstrb_split_ctrl #(
  parameter int AXI_DWIDTH    = 64,
  parameter int AXI_STRBWIDTH = 8,
  parameter int BYTECNT_WIDTH = 12
) (
  input logic                           ACLK,
  input logic                           ARESETN,
  coreaxitoahbl_wstrb_split_ctrl_if.slave bus
);
  import coreaxitoahbl_wstrb_split_ctrl_pkg::*;

  localparam logic DW64 = (AXI_DWIDTH == 64);

  state_e                   r_state, w_state_nxt;
  logic [2:0]               r_off, w_off_nxt;
  logic [3:0]               r_len, w_len_nxt;
  logic                     r_last, w_last_nxt;
  logic                     r_first, w_first_nxt;
  logic [BYTECNT_WIDTH-1:0] r_byte_cnt, w_byte_cnt_nxt;
  logic                     r_beat_ready, r_xfer_valid, r_xfer_beatend;
  logic                     r_strb_err, r_burst_done;
  logic [2:0]               r_xfer_offset, r_xfer_size;
  logic                     w_strb_err_nxt, w_burst_done_nxt;
  logic [3:0]               w_popcnt;
  logic [2:0]               w_lsb;
  logic [2:0]               w_cur_size, w_nxt_size;
  logic [3:0]               w_cur_bytes, w_nxt_bytes;
  logic                     w_capture, w_xfer_hs;
  logic [BYTECNT_WIDTH-1:0] w_popcnt_ext;

  coreaxitoahbl_wstrb_split_ctrl_popcntr #(
    .AXI_DWIDTH    (AXI_DWIDTH),
    .AXI_STRBWIDTH (AXI_STRBWIDTH)
  ) u_popcntr (
    .i_wstrb (bus.BEAT_WSTRB),
    .o_cnt   (w_popcnt)
  );

  // Priority encoder: index of the lowest set strobe lane.
  always_comb begin
    w_lsb = 3'd0;
    for (int i = AXI_STRBWIDTH - 1; i >= 0; i--) begin
      if (bus.BEAT_WSTRB[i]) begin
        w_lsb = 3'(i);
      end else begin
        w_lsb = w_lsb;
      end
    end
  end

  // BEAT_READY is only high in IDLE, so it alone qualifies a capture.
  assign w_capture    = r_beat_ready & bus.BEAT_VALID;
  assign w_xfer_hs    = r_xfer_valid & bus.XFER_READY;
  assign w_popcnt_ext = {{(BYTECNT_WIDTH-4){1'b0}}, w_popcnt};
  assign w_cur_size   = size_sel(r_off, r_len, DW64);
  assign w_cur_bytes  = size_bytes(w_cur_size);
  assign w_nxt_size   = size_sel(w_off_nxt, w_len_nxt, DW64);
  assign w_nxt_bytes  = size_bytes(w_nxt_size);

  // Next-state, beat bookkeeping and pulse decisions.
  always_comb begin
    w_state_nxt      = r_state;
    w_off_nxt        = r_off;
    w_len_nxt        = r_len;
    w_last_nxt       = r_last;
    w_first_nxt      = r_first;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_strb_err_nxt   = 1'b0;
    w_burst_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_off_nxt   = w_lsb;
          w_len_nxt   = w_popcnt;
          w_last_nxt  = bus.BEAT_LAST;
          w_first_nxt = bus.BEAT_LAST;
          if (r_first) begin
            w_byte_cnt_nxt = w_popcnt_ext;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + w_popcnt_ext;
          end
          if (w_popcnt != 4'd0) begin
            w_state_nxt = ST_SPLIT;
          end else begin
            // Empty or rejected beat: nothing to transfer.
            w_strb_err_nxt   = (bus.BEAT_WSTRB != '0);
            w_burst_done_nxt = bus.BEAT_LAST;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SPLIT: begin
        if (w_xfer_hs) begin
          // An 8-byte step wraps the 3-bit offset back to lane 0.
          w_off_nxt = r_off + w_cur_bytes[2:0];
          w_len_nxt = r_len - w_cur_bytes;
          if (r_len == w_cur_bytes) begin
            w_state_nxt      = ST_IDLE;
            w_burst_done_nxt = r_last;
          end else begin
            w_state_nxt = ST_SPLIT;
          end
        end else begin
          w_state_nxt = ST_SPLIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, beat context and registered outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state        <= ST_IDLE;
      r_off          <= 3'd0;
      r_len          <= 4'd0;
      r_last         <= 1'b0;
      r_first        <= 1'b1;
      r_byte_cnt     <= '0;
      r_beat_ready   <= 1'b0;
      r_xfer_valid   <= 1'b0;
      r_xfer_offset  <= 3'd0;
      r_xfer_size    <= 3'd0;
      r_xfer_beatend <= 1'b0;
      r_strb_err     <= 1'b0;
      r_burst_done   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_off          <= w_off_nxt;
      r_len          <= w_len_nxt;
      r_last         <= w_last_nxt;
      r_first        <= w_first_nxt;
      r_byte_cnt     <= w_byte_cnt_nxt;
      r_beat_ready   <= (w_state_nxt == ST_IDLE);
      r_xfer_valid   <= (w_state_nxt == ST_SPLIT);
      r_xfer_offset  <= (w_state_nxt == ST_SPLIT) ? w_off_nxt : 3'd0;
      r_xfer_size    <= (w_state_nxt == ST_SPLIT) ? w_nxt_size : 3'd0;
      r_xfer_beatend <= (w_state_nxt == ST_SPLIT) && (w_len_nxt == w_nxt_bytes);
      r_strb_err     <= w_strb_err_nxt;
      r_burst_done   <= w_burst_done_nxt;
    end
  end

  assign bus.BEAT_READY   = r_beat_ready;
  assign bus.XFER_VALID   = r_xfer_valid;
  assign bus.XFER_OFFSET  = r_xfer_offset;
  assign bus.XFER_SIZE    = r_xfer_size;
  assign bus.XFER_BEATEND = r_xfer_beatend;
  assign bus.STRB_ERR     = r_strb_err;
  assign bus.BURST_DONE   = r_burst_done;
  assign bus.BYTE_CNT     = r_byte_cnt;
endmodule
